// File: rtl/control_unit.sv
// control_unit: main opcode decoder for the single-issue MIPS-style datapath.
// Every control output is registered and reflects the opcode sampled at the
// previous rising clk edge. Edge priority is flush > stall > decode.
// The optional immediate-logic rows (andi/ori/slti) are enabled by defining
// CTRL_IMM_LOGIC_EN. Without it those opcodes decode as illegal.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       stall,
  input  logic       flush,
  output logic       branch,
  output logic       RegDst,
  output logic       MemRead,
  output logic       MemToWrite,
  output logic       MemToReg,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       illegal_op
);

  // Opcode encodings (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation classes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Control word held in a single register so flush/stall/reset act uniformly.
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // Combinational decode of the incoming opcode into the next control word.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_RTYPE;
      end
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branch   = 1'b1;
        dec.aluop    = ALU_SUB;
      end
      OP_ADDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      // Jump target is resolved elsewhere; no control side effects here.
      OP_J: begin
        dec = '0;
      end
`ifdef CTRL_IMM_LOGIC_EN
      OP_ANDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_AND;
      end
      OP_ORI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_OR;
      end
      OP_SLTI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_SLT;
      end
`endif
      default: begin
        dec         = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Output register: async clear, then flush > stall > decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!stall) begin
      ctrl_q <= dec;
    end
  end

  assign RegDst     = ctrl_q.regdst;
  assign ALUSrc     = ctrl_q.alusrc;
  assign MemToReg   = ctrl_q.memtoreg;
  assign RegWrite   = ctrl_q.regwrite;
  assign MemRead    = ctrl_q.memread;
  assign MemToWrite = ctrl_q.memwrite;
  assign branch     = ctrl_q.branch;
  assign ALUOp      = ctrl_q.aluop;
  assign illegal_op = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit.
// Expected control words are pushed to a scoreboard queue when an opcode is
// driven and popped after the clock edge that registers it.
// Expectations for andi/ori/slti follow CTRL_IMM_LOGIC_EN.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       stall;
  logic       flush;
  logic       branch, RegDst, MemRead, MemToWrite, MemToReg, ALUSrc, RegWrite, illegal_op;
  logic [2:0] ALUOp;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .stall      (stall),
    .flush      (flush),
    .branch     (branch),
    .RegDst     (RegDst),
    .MemRead    (MemRead),
    .MemToWrite (MemToWrite),
    .MemToReg   (MemToReg),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op)
  );

  // Observed word, field order: RegDst ALUSrc MemToReg RegWrite MemRead MemToWrite branch ALUOp illegal_op
  logic [10:0] obs;
  assign obs = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemToWrite, branch, ALUOp, illegal_op};

  logic [10:0] sb[$];
  logic [10:0] cur;
  logic [10:0] exp;
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  // Reference decode table.
  function automatic logic [10:0] model(input logic [5:0] op);
    logic [10:0] w;
    case (op)
      6'b000000: w = 11'b1_0_0_1_0_0_0_010_0;
      6'b100011: w = 11'b0_1_1_1_1_0_0_000_0;
      6'b101011: w = 11'b0_1_0_0_0_1_0_000_0;
      6'b000100: w = 11'b0_0_0_0_0_0_1_001_0;
      6'b001000: w = 11'b0_1_0_1_0_0_0_000_0;
      6'b000010: w = 11'b0_0_0_0_0_0_0_000_0;
`ifdef CTRL_IMM_LOGIC_EN
      6'b001100: w = 11'b0_1_0_1_0_0_0_011_0;
      6'b001101: w = 11'b0_1_0_1_0_0_0_100_0;
      6'b001010: w = 11'b0_1_0_1_0_0_0_101_0;
`endif
      default:   w = 11'b0_0_0_0_0_0_0_000_1;
    endcase
    return w;
  endfunction

  // Drive one cycle of stimulus at negedge, queue its expected result, and
  // return 1 time unit after the registering edge.
  task automatic drive(input logic [5:0] op, input logic st, input logic fl);
    @(negedge clk);
    opcode = op;
    stall  = st;
    flush  = fl;
    if (fl)      cur = '0;
    else if (!st) cur = model(op);
    sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b000000; stall = 1'b0; flush = 1'b0; cur = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 11'b0) begin $display("FAIL reset_init: got=%b exp=%b", obs, 11'b0); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b000000, 1'b0, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin $display("FAIL rtype_after_reset: got=%b exp=%b", obs, exp); bad++; end
    // Mid-cycle asynchronous assertion, checked before any clk edge.
    #2;
    rst_n = 1'b0;
    #1;
    cur = '0;
    total++;
    if (obs !== 11'b0) begin $display("FAIL async_reset: got=%b exp=%b", obs, 11'b0); bad++; end
    @(posedge clk);
    #1;
    total++;
    if (obs !== 11'b0) begin $display("FAIL reset_hold: got=%b exp=%b", obs, 11'b0); bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b000000, 1'b0, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp || RegDst !== 1'b1 || RegWrite !== 1'b1 || MemToReg !== 1'b0 ||
        MemToWrite !== 1'b0 || ALUOp !== 3'b010) begin
      $display("FAIL reset_release: got=%b exp=%b", obs, exp); bad++;
    end
  endtask

  task automatic test_sweep();
    logic [5:0] ops [4];
    ops = '{6'b000000, 6'b000010, 6'b001000, 6'b111111};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin $display("FAIL sweep_%b: got=%b exp=%b", ops[i], obs, exp); bad++; end
      // Changing opcode between edges must not disturb the outputs.
      opcode = ~ops[i];
      #1;
      total++;
      if (obs !== exp) begin $display("FAIL no_comb_path_%b: got=%b exp=%b", ops[i], obs, exp); bad++; end
    end
  endtask

  task automatic test_mem_branch();
    logic [5:0] ops [3];
    ops = '{6'b100011, 6'b101011, 6'b000100};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin $display("FAIL membr_%b: got=%b exp=%b", ops[i], obs, exp); bad++; end
      total++;
      if ((MemRead & MemToWrite) !== 1'b0 || ((MemToWrite | branch) & RegWrite) !== 1'b0) begin
        $display("FAIL invariant_%b: got=%b exp=no_conflict", ops[i], obs); bad++;
      end
    end
  endtask

  task automatic test_stall();
    drive(6'b100011, 1'b0, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin $display("FAIL stall_pre_lw: got=%b exp=%b", obs, exp); bad++; end
    for (int i = 0; i < 2; i++) begin
      drive(6'b101011, 1'b1, 1'b0);
      exp = sb.pop_front();
      total++;
      if (obs !== exp || MemRead !== 1'b1) begin $display("FAIL stall_hold%0d: got=%b exp=%b", i, obs, exp); bad++; end
    end
    drive(6'b101011, 1'b0, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp || MemToWrite !== 1'b1) begin $display("FAIL stall_release: got=%b exp=%b", obs, exp); bad++; end
  endtask

  task automatic test_flush();
    drive(6'b111111, 1'b0, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin $display("FAIL flush_pre_illegal: got=%b exp=%b", obs, exp); bad++; end
    drive(6'b000000, 1'b1, 1'b1);
    exp = sb.pop_front();
    total++;
    if (obs !== exp || illegal_op !== 1'b0) begin $display("FAIL flush_over_stall: got=%b exp=%b", obs, exp); bad++; end
    drive(6'b000000, 1'b1, 1'b0);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin $display("FAIL flush_then_stall: got=%b exp=%b", obs, exp); bad++; end
    drive(6'b100011, 1'b0, 1'b1);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin $display("FAIL flush_plain: got=%b exp=%b", obs, exp); bad++; end
  endtask

  task automatic test_imm_logic();
    logic [5:0] ops [3];
    ops = '{6'b001100, 6'b001101, 6'b001010};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin $display("FAIL imm_%b: got=%b exp=%b", ops[i], obs, exp); bad++; end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pool [10];
    logic [5:0] op;
    logic st, fl;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
             6'b000010, 6'b001100, 6'b001101, 6'b001010, 6'b000110};
    for (int i = 0; i < 60; i++) begin
      op = pool[$urandom_range(9, 0)];
      st = ($urandom_range(4, 0) == 0);
      fl = ($urandom_range(7, 0) == 0);
      drive(op, st, fl);
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin $display("FAIL b2b_%0d op=%b st=%b fl=%b: got=%b exp=%b", i, op, st, fl, obs, exp); bad++; end
      total++;
      if ((MemRead & MemToWrite) !== 1'b0 || ((MemToWrite | branch) & RegWrite) !== 1'b0 ||
          ALUOp[2:1] === 2'b11) begin
        $display("FAIL b2b_invariant_%0d: got=%b exp=no_conflict", i, obs); bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mem_branch();
    test_stall();
    test_flush();
    test_imm_logic();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin $display("FAIL scoreboard_drain: got=%0d exp=0", sb.size()); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
